pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipelined RV32 datapath. It drives StallF, StallD, FlushD, FlushE, ForwardAE and ForwardBE from stage register indices and control bits. It adds a debug halt/drain handshake that empties E/M/W and parks the pipeline. Optional performance counters track stalls and flushes.

---
 rtl/pipeline_hazard_ctrl_if.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32 datapath (master) and pipeline_hazard_ctrl (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, halt_req;
  logic             StallF, StallD, FlushD, FlushE, halt_ack;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_count, flush_count;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, halt_req,
    input  StallF, StallD, FlushD, FlushE, halt_ack,
    input  ForwardAE, ForwardBE, stall_count, flush_count
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, halt_req,
    output StallF, StallD, FlushD, FlushE, halt_ack,
    output ForwardAE, ForwardBE, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline with debug halt/drain.
// Define PERF_COUNTERS_EN to build the stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e            state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              lw_stall;

  // M stage wins over W; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != 5'd0) begin
      if (wr_m && (rd_m == rs))      sel = 2'b10;
      else if (wr_w && (rd_w == rs)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    lw_stall     = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                   ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
  end

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hz.StallF   = 1'b1;
    hz.StallD   = 1'b1;
    hz.FlushD   = 1'b0;
    hz.FlushE   = 1'b1;
    hz.halt_ack = 1'b0;
    unique case (state_q)
      RUN: begin
        hz.StallF = lw_stall;
        hz.StallD = lw_stall;
        hz.FlushD = hz.PCSrcE;
        hz.FlushE = lw_stall || hz.PCSrcE;
        dcnt_d    = '0;
        // A pending redirect or load-use stall must resolve before draining.
        if (hz.halt_req && !hz.PCSrcE && !lw_stall) state_d = DRAIN;
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DCNT_LAST) begin
          state_d = HALTED;
          dcnt_d  = '0;
        end
      end
      HALTED: begin
        hz.halt_ack = 1'b1;
        if (!hz.halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (state_q == RUN) begin
      if (lw_stall)  stall_count_d = stall_count_q + 1'b1;
      if (hz.PCSrcE) flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  always_comb begin
    hz.stall_count = stall_count_q;
    hz.flush_count = flush_count_q;
  end
`else
  always_comb begin
    hz.stall_count = '0;
    hz.flush_count = '0;
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard/halt scenarios, then random traffic.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       lw, pc, rwm, rww, hr;
  } stim_t;

  typedef struct {
    int unsigned      cyc;
    logic             sf, sd, fd, fe, ack;
    logic [1:0]       fa, fb;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  exp_t exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cycle = 0;
  bit armed = 0;

  // Reference model: halted flag plus number of drain cycles still owed.
  bit               m_halted = 0;
  int               m_drain_left = 0;
  logic [CNT_W-1:0] m_sc = '0, m_fc = '0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, rs1d: 5'd0, rs2d: 5'd0, rs1e: 5'd0, rs2e: 5'd0, rde: 5'd0,
          rdm: 5'd0, rdw: 5'd0, lw: 1'b0, pc: 1'b0, rwm: 1'b0, rww: 1'b0, hr: 1'b0};
    return s;
  endfunction

  function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] rs);
    if (rs == 0) return 2'd0;
    if (s.rwm && s.rdm == rs) return 2'd2;
    if (s.rww && s.rdw == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit lw_hit, busy;
    @(posedge clk);
    #1;
    cycle++;
    rst = s.rst;
    hz.Rs1D = s.rs1d; hz.Rs2D = s.rs2d; hz.Rs1E = s.rs1e; hz.Rs2E = s.rs2e;
    hz.RdE = s.rde; hz.RdM = s.rdm; hz.RdW = s.rdw;
    hz.ResultSrcE0 = s.lw; hz.PCSrcE = s.pc; hz.RegWriteM = s.rwm;
    hz.RegWriteW = s.rww; hz.halt_req = s.hr;

    lw_hit = s.lw && s.rde != 0 && (s.rs1d == s.rde || s.rs2d == s.rde);
    busy   = m_halted || (m_drain_left > 0);
    e.cyc = cycle;
    e.fa  = ref_fwd(s, s.rs1e);
    e.fb  = ref_fwd(s, s.rs2e);
    e.sf  = busy ? 1'b1 : lw_hit;
    e.sd  = e.sf;
    e.fd  = busy ? 1'b0 : s.pc;
    e.fe  = busy ? 1'b1 : (lw_hit || s.pc);
    e.ack = m_halted;
`ifdef PERF_COUNTERS_EN
    e.sc = m_sc;
    e.fc = m_fc;
`else
    e.sc = '0;
    e.fc = '0;
`endif
    if (armed) exp_q.push_back(e);
    armed = 1;

    if (s.rst) begin
      m_halted = 0; m_drain_left = 0; m_sc = '0; m_fc = '0;
    end else if (m_halted) begin
      if (!s.hr) m_halted = 0;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else begin
      if (lw_hit) m_sc = m_sc + 1'b1;
      if (s.pc)   m_fc = m_fc + 1'b1;
      if (s.hr && !s.pc && !lw_hit) m_drain_left = DRAIN_CYCLES;
    end
  endtask

  task automatic chk(input string name, input int unsigned cyc, input logic [31:0] act,
                     input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("StallF",      e.cyc, 32'(hz.StallF),      32'(e.sf));
      chk("StallD",      e.cyc, 32'(hz.StallD),      32'(e.sd));
      chk("FlushD",      e.cyc, 32'(hz.FlushD),      32'(e.fd));
      chk("FlushE",      e.cyc, 32'(hz.FlushE),      32'(e.fe));
      chk("ForwardAE",   e.cyc, 32'(hz.ForwardAE),   32'(e.fa));
      chk("ForwardBE",   e.cyc, 32'(hz.ForwardBE),   32'(e.fb));
      chk("halt_ack",    e.cyc, 32'(hz.halt_ack),    32'(e.ack));
      chk("stall_count", e.cyc, 32'(hz.stall_count), 32'(e.sc));
      chk("flush_count", e.cyc, 32'(hz.flush_count), 32'(e.fc));
    end
  end

  initial begin
    stim_t s;
    logic  hr_level;
    int    guard;

    s = idle(); s.rst = 1'b1;
    apply(s); apply(s);
    s = idle(); apply(s);

    // Forwarding priority: M over W, never for x0.
    s = idle(); s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; s.rs1e = 5; s.rs2e = 5;
    apply(s);
    s.rwm = 0; apply(s);
    s.rwm = 1; s.rs1e = 0; s.rs2e = 0; apply(s);

    // Load-use stall then taken branch.
    s = idle(); s.lw = 1; s.rde = 7; s.rs2d = 7; apply(s);
    s = idle(); apply(s);
    s.pc = 1; apply(s);
    s = idle(); apply(s);

    // Clean halt, park, release.
    s = idle(); s.hr = 1;
    repeat (6) apply(s);
    s.hr = 0; apply(s); apply(s);

    // Halt coinciding with a redirect.
    s = idle(); s.hr = 1; s.pc = 1; apply(s);
    s.pc = 0; repeat (6) apply(s);
    s.hr = 0; apply(s); apply(s);

    // Reset in the second drain cycle.
    s = idle(); s.hr = 1; apply(s); apply(s);
    s.rst = 1; apply(s);
    s = idle(); s.lw = 1; s.rde = 3; s.rs1d = 3; apply(s);
    s = idle(); apply(s);

    // Random traffic over a small register range so hazards collide often.
    hr_level = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) hr_level = ~hr_level;
      s.rst  = ($urandom_range(0, 249) == 0);
      s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
      s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
      s.rde  = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
      s.rdw  = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) s.rs1e = 5'($urandom_range(0, 31));
      s.lw  = ($urandom_range(0, 2) == 0);
      s.pc  = ($urandom_range(0, 5) == 0);
      s.rwm = $urandom_range(0, 1);
      s.rww = $urandom_range(0, 1);
      s.hr  = hr_level;
      apply(s);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
